// File: rtl/key_ctrl.sv
// key_ctrl: turns synchronized PS/2 key levels into per-frame player
// commands (walk direction, facing, buffered multi-jump, auto-fire).
module key_ctrl #(
  parameter int unsigned BUF_FRAMES   = 6,
  parameter int unsigned MAX_JUMPS    = 2,
  parameter int unsigned HOLD_FRAMES  = 12,
  parameter int unsigned SHOOT_REPEAT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keys,
  input  logic       frame_tick,
  input  logic       grounded,
  output logic [1:0] dir,
  output logic       face,
  output logic       jump_start,
  output logic       jump_hold,
  output logic       shoot,
  output logic [1:0] jumps_left
);

  localparam logic [3:0] BufLd  = 4'(BUF_FRAMES);
  localparam logic [1:0] JMax   = 2'(MAX_JUMPS);
  localparam logic [4:0] HoldLd = 5'(HOLD_FRAMES);
  localparam logic [4:0] RepLd  = 5'(SHOOT_REPEAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_e;

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] prev_q, prev_d;
  logic       gprev_q, gprev_d;
  logic [1:0] pri_q, pri_d;
  logic [1:0] dir_q, dir_d;
  logic       face_q, face_d;
  logic [3:0] buf_q, buf_d;
  logic [3:0] buf_eff;
  logic [4:0] hold_q, hold_d;
  logic [4:0] rep_q, rep_d;
  state_e     state_q, state_d;
  logic [1:0] jl_q, jl_d;
  logic       js_q, js_d;
  logic       jh_q, jh_d;
  logic       sh_q, sh_d;
  logic [3:0] press;

  // Bring asynchronous key levels into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0;
      sync2_q <= 4'b0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  assign press = sync2_q & ~prev_q;

  // Per-frame decisions; outside a frame tick only the pulses drop.
  always_comb begin
    prev_d  = prev_q;
    gprev_d = gprev_q;
    pri_d   = pri_q;
    dir_d   = dir_q;
    face_d  = face_q;
    buf_d   = buf_q;
    buf_eff = buf_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    state_d = state_q;
    jl_d    = jl_q;
    jh_d    = jh_q;
    js_d    = 1'b0;
    sh_d    = 1'b0;
    if (frame_tick) begin
      prev_d  = sync2_q;
      gprev_d = grounded;

      // Later press wins when both directions are held.
      if (press[3] && press[2]) begin
        pri_d = 2'b00;
      end else if (press[3]) begin
        pri_d = 2'b10;
      end else if (press[2]) begin
        pri_d = 2'b01;
      end
      case (sync2_q[3:2])
        2'b10:   dir_d = 2'b10;
        2'b01:   dir_d = 2'b01;
        2'b11:   dir_d = pri_d;
        default: dir_d = 2'b00;
      endcase
      if (dir_d != 2'b00) begin
        face_d = dir_d[1];
      end

      // Refill on ground, or charge a jump for walking off a ledge.
      if (grounded && state_q != RISE) begin
        jl_d    = JMax;
        state_d = IDLE;
      end else if (gprev_q && !grounded && state_q == IDLE) begin
        jl_d    = JMax - 2'd1;
        state_d = FALL;
      end

      if (state_q == RISE) begin
        hold_d = (hold_q != 5'd0) ? hold_q - 5'd1 : 5'd0;
        if (!sync2_q[0] || hold_d == 5'd0) begin
          state_d = FALL;
        end
      end

      buf_eff = press[0] ? BufLd : buf_q;
      if (buf_eff != 4'd0 && jl_d != 2'd0) begin
        js_d    = 1'b1;
        jl_d    = jl_d - 2'd1;
        buf_d   = 4'd0;
        hold_d  = HoldLd;
        state_d = RISE;
      end else if (press[0]) begin
        buf_d = BufLd;
      end else if (buf_q != 4'd0) begin
        buf_d = buf_q - 4'd1;
      end

      jh_d = (state_d == RISE);

      // Fire on press, then every SHOOT_REPEAT frames while held.
      if (press[1]) begin
        sh_d  = 1'b1;
        rep_d = RepLd;
      end else if (sync2_q[1]) begin
        if (rep_q <= 5'd1) begin
          sh_d  = 1'b1;
          rep_d = RepLd;
        end else begin
          rep_d = rep_q - 5'd1;
        end
      end else begin
        rep_d = 5'd0;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 4'b0;
      gprev_q <= 1'b0;
      pri_q   <= 2'b00;
      dir_q   <= 2'b00;
      face_q  <= 1'b0;
      buf_q   <= 4'd0;
      hold_q  <= 5'd0;
      rep_q   <= 5'd0;
      state_q <= IDLE;
      jl_q    <= JMax;
      js_q    <= 1'b0;
      jh_q    <= 1'b0;
      sh_q    <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      gprev_q <= gprev_d;
      pri_q   <= pri_d;
      dir_q   <= dir_d;
      face_q  <= face_d;
      buf_q   <= buf_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      state_q <= state_d;
      jl_q    <= jl_d;
      js_q    <= js_d;
      jh_q    <= jh_d;
      sh_q    <= sh_d;
    end
  end

  assign dir        = dir_q;
  assign face       = face_q;
  assign jump_start = js_q;
  assign jump_hold  = jh_q;
  assign shoot      = sh_q;
  assign jumps_left = jl_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed frame-by-frame vectors with a queued
// scoreboard checked by an independent monitor after each frame tick.
module tb_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys;
  logic       frame_tick;
  logic       grounded;
  logic [1:0] dir;
  logic       face;
  logic       jump_start;
  logic       jump_hold;
  logic       shoot;
  logic [1:0] jumps_left;

  localparam logic [3:0] KJ = 4'b0001;
  localparam logic [3:0] KS = 4'b0010;
  localparam logic [3:0] KR = 4'b0100;
  localparam logic [3:0] KL = 4'b1000;

  typedef struct packed {
    logic [1:0] dir;
    logic       face;
    logic       js;
    logic       jh;
    logic       sh;
    logic [1:0] jl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_no = 0;

  key_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .frame_tick (frame_tick),
    .grounded   (grounded),
    .dir        (dir),
    .face       (face),
    .jump_start (jump_start),
    .jump_hold  (jump_hold),
    .shoot      (shoot),
    .jumps_left (jumps_left)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] d, input logic f,
                              input logic js, input logic jh,
                              input logic sh, input logic [1:0] jl);
    exp_t e;
    e.dir  = d;
    e.face = f;
    e.js   = js;
    e.jh   = jh;
    e.sh   = sh;
    e.jl   = jl;
    return e;
  endfunction

  function automatic exp_t outs();
    return mk(dir, face, jump_start, jump_hold, shoot, jumps_left);
  endfunction

  task automatic chk(input string name, input int idx,
                     input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d: got dir=%b face=%b js=%b jh=%b sh=%b jl=%0d, expected dir=%b face=%b js=%b jh=%b sh=%b jl=%0d",
               name, idx, act.dir, act.face, act.js, act.jh, act.sh,
               act.jl, req.dir, req.face, req.js, req.jh, req.sh, req.jl);
    end
  endtask

  task automatic tick(input logic [3:0] k, input logic g, input exp_t e);
    @(negedge clk);
    keys     = k;
    grounded = g;
    repeat (3) @(negedge clk);
    q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Monitor: compare after every frame tick, then check pulses drop.
  always @(posedge clk) begin
    if (frame_tick && rst_n) begin
      #1;
      tick_no++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick #%0d: got output with empty queue, expected none",
                 tick_no);
      end else begin
        chk("tick", tick_no, outs(), q.pop_front());
      end
      @(posedge clk);
      #1;
      checks++;
      if (jump_start !== 1'b0 || shoot !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width #%0d: got js=%b sh=%b, expected 0 0",
                 tick_no, jump_start, shoot);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    keys       = 4'b0;
    grounded   = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 0, outs(), mk(2'b00, 0, 0, 0, 0, 2'd2));
    rst_n = 1'b1;

    // Ground jump, key held long: hold window caps at 12 frames.
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));
    tick(KJ, 1, mk(2'b00, 0, 1, 1, 0, 2'd1));
    for (int i = 1; i <= 20; i++) begin
      tick(KJ, 1, mk(2'b00, 0, 0, (i < 12), 0, (i <= 12) ? 2'd1 : 2'd2));
    end
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Double jump, third press denied, buffer expires before landing.
    tick(KJ, 1, mk(2'b00, 0, 1, 1, 0, 2'd1));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd1));
    tick(KJ, 0, mk(2'b00, 0, 1, 1, 0, 2'd0));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(KJ, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    for (int i = 0; i < 9; i++) begin
      tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    end
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Press 3 frames before landing: jump fires on the landing frame.
    tick(KJ, 1, mk(2'b00, 0, 1, 1, 0, 2'd1));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd1));
    tick(KJ, 0, mk(2'b00, 0, 1, 1, 0, 2'd0));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(KJ, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(4'b0, 1, mk(2'b00, 0, 1, 1, 0, 2'd1));
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd1));
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Ledge walk-off costs one jump.
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd1));
    tick(KJ, 0, mk(2'b00, 0, 1, 1, 0, 2'd0));
    tick(4'b0, 0, mk(2'b00, 0, 0, 0, 0, 2'd0));
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Direction priority and facing.
    tick(KL, 1, mk(2'b10, 1, 0, 0, 0, 2'd2));
    tick(KL | KR, 1, mk(2'b01, 0, 0, 0, 0, 2'd2));
    tick(KL, 1, mk(2'b10, 1, 0, 0, 0, 2'd2));
    tick(4'b0, 1, mk(2'b00, 1, 0, 0, 0, 2'd2));
    tick(KL | KR, 1, mk(2'b00, 1, 0, 0, 0, 2'd2));
    tick(KR, 1, mk(2'b01, 0, 0, 0, 0, 2'd2));
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Auto-fire while held, fresh shot on re-press.
    for (int i = 0; i < 25; i++) begin
      tick(KS, 1, mk(2'b00, 0, 0, 0, (i % 10 == 0), 2'd2));
    end
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));
    tick(KS, 1, mk(2'b00, 0, 0, 0, 1, 2'd2));
    tick(4'b0, 1, mk(2'b00, 0, 0, 0, 0, 2'd2));

    // Reset during RISE, keys held through it.
    tick(KL | KJ, 1, mk(2'b10, 1, 1, 1, 0, 2'd1));
    tick(KL | KJ, 1, mk(2'b10, 1, 0, 1, 0, 2'd1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_rise", 0, outs(), mk(2'b00, 0, 0, 0, 0, 2'd2));
    repeat (2) @(negedge clk);
    chk("reset_hold", 0, outs(), mk(2'b00, 0, 0, 0, 0, 2'd2));
    rst_n = 1'b1;
    tick(KL | KJ, 1, mk(2'b10, 1, 1, 1, 0, 2'd1));
    tick(4'b0, 1, mk(2'b00, 1, 0, 0, 0, 2'd1));

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
KEY_CTRL -- requirements
Module: key_ctrl

Interface
Parameters:
REQ-001 BUF_FRAMES, 6, frames a jump press stays buffered before it is discarded (1..15).
REQ-002 MAX_JUMPS, 2, jumps available per ground contact (1..3).
REQ-003 HOLD_FRAMES, 12, maximum frames jump_hold may stay high after a jump_start (1..31).
REQ-004 SHOOT_REPEAT, 10, frames between auto-repeat shots while shoot is held (2..31).
Ports:
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 keys  input  4  level key states from the PS/2 driver: [3] left, [2] right, [1] shoot, [0] jump; 1 = held.
REQ-008 frame_tick  input  1  one-clk pulse per game frame.
REQ-009 grounded  input  1  player standing on solid ground, valid on frame_tick.
REQ-010 dir  output  2  horizontal command: 00 none, 01 right, 10 left; 11 never driven.
REQ-011 face  output  1  facing: 0 right, 1 left.
REQ-012 jump_start  output  1  one-clk pulse starting a jump.
REQ-013 jump_hold  output  1  level; player is still rising under key control.
REQ-014 shoot  output  1  one-clk pulse requesting a bullet.
REQ-015 jumps_left  output  2  remaining jumps.

Function
REQ-016 keys SHALL pass through a 2-flop synchronizer; all decisions use synchronized values sampled on frame_tick only.
REQ-017 Press/release edges SHALL be detected against the value sampled at the previous frame_tick.
REQ-018 dir: only left held -> 10; only right held -> 01; neither -> 00; both held -> the key whose press edge came later; equal-tick presses -> 00.
REQ-019 face SHALL update to the direction of any nonzero dir and hold otherwise.
REQ-020 Jump press edge SHALL load buf_cnt = BUF_FRAMES; buf_cnt SHALL decrement by 1 per frame_tick, saturating at 0.
REQ-021 Jump FSM states: IDLE, RISE, FALL.
REQ-022 On frame_tick with grounded=1 and state != RISE: jumps_left <= MAX_JUMPS, state <= IDLE.
REQ-023 On frame_tick with grounded falling 1->0 while state == IDLE: jumps_left <= MAX_JUMPS-1 (ledge walk-off costs one jump), state <= FALL.
REQ-024 Jump issue: on frame_tick with buf_cnt>0 (including a same-tick press) and jumps_left (after REQ-022/023) > 0: jump_start high for that clk, jumps_left decrements, buf_cnt <= 0, hold_cnt <= HOLD_FRAMES, state <= RISE.
REQ-025 A grounded refill and a buffered press on the same tick SHALL issue the jump using the refilled count.
REQ-026 RISE: jump_hold = 1; each frame_tick hold_cnt decrements; jump key released or hold_cnt reaching 0 -> FALL at that tick.
REQ-027 A new jump issue in RISE or FALL (double jump) SHALL restart RISE with hold_cnt = HOLD_FRAMES.
REQ-028 FALL -> IDLE on frame_tick with grounded=1; jump_hold = 0 outside RISE.
REQ-029 Buffered press with jumps_left == 0 SHALL stay buffered until buf_cnt expires or a landing refills.
REQ-030 shoot: press edge -> shoot pulse and rep_cnt <= SHOOT_REPEAT; while held, rep_cnt decrements each tick and pulses/reloads at 0; release clears rep_cnt.
REQ-031 All output pulses SHALL be exactly one clk wide, coincident with the frame_tick clk; no output changes between frame_ticks except pulse deassertion.

Reset
REQ-032 rst_n low SHALL immediately force: dir=00, face=0, jump_start=0, jump_hold=0, shoot=0, jumps_left=MAX_JUMPS, state IDLE, all counters and synchronizer/edge history 0.
REQ-033 Reset mid-jump SHALL abort with no residual pulse; keys held through release SHALL be seen as a new press edge at the first frame_tick.

Verification
REQ-034 grounded=1, press jump, hold 20 ticks -> jump_start once, jump_hold high exactly 12 ticks, jumps_left 2->1.
REQ-035 Airborne, jump pressed 3 ticks before landing -> jump_start on landing tick, jumps_left reads 1 after.
REQ-036 Two presses in air after first jump -> second jump_start issued, third press gives none, jumps_left 0; landing restores 2.
REQ-037 Hold left, then press right while left held -> dir 10 then 01; release right -> 10; face follows.
REQ-038 Hold shoot 25 ticks -> shoot pulses at ticks 0, 10, 20.
REQ-039 Assert rst_n low during RISE -> all outputs at reset values same cycle, jumps_left=2.
